// File: rtl/sel_mux_pkg.sv
// ============================================================================
// Module      : sel_mux_pkg
// Description : Shared defaults, limits and elaboration helpers for sel_mux_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sel_mux_pkg;

    localparam int DEFAULT_WIDTH  = 5;
    localparam int DEFAULT_NUM_IN = 3;
    localparam int DEFAULT_DEPTH  = 1;
    localparam int MAX_DEPTH      = 4;
    localparam int MAX_IN         = 16;

    // Smallest select width able to address n operands (never below 1 bit).
    function automatic int min_sel_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage : sel_mux_pkg

`default_nettype wire

// File: rtl/sel_mux_stage.sv
// ============================================================================
// Module      : sel_mux_stage
// Description : One valid/data register slice of the valid/ready pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sel_mux_stage #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             rdy_in,
    output logic             rdy_out,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A slot can take a new item when it is empty or its item moves on.
    assign rdy_out   = !r_valid | rdy_in;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (rdy_out) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= in_data;
            end
        end
    end

endmodule : sel_mux_stage

`default_nettype wire

// File: rtl/sel_mux_pipe.sv
// ============================================================================
// Module      : sel_mux_pipe
// Description : NUM_IN-way operand selector feeding a DEPTH-stage valid/ready
//               pipeline with stall and flush. Optional macro
//               SEL_MUX_PIPE_SELCHK_EN adds a sticky out-of-range select flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sel_mux_pipe
    import sel_mux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        dout,
    output logic                    out_valid,
`ifdef SEL_MUX_PIPE_SELCHK_EN
    output logic                    sel_err,
`endif
    input  logic                    out_ready
);

    generate
        if (NUM_IN < 2 || NUM_IN > MAX_IN || DEPTH < 1 || DEPTH > MAX_DEPTH ||
            SEL_W < min_sel_w(NUM_IN)) begin : g_param_err
            $error("sel_mux_pipe: illegal NUM_IN/SEL_W/DEPTH combination");
        end
    endgenerate

    logic [WIDTH-1:0] w_sel_data;

    // Out-of-range selects fall back to operand 0, matching the legacy selector.
    always_comb begin
        w_sel_data = din[WIDTH-1:0];
        for (int i = 1; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                w_sel_data = din[i*WIDTH +: WIDTH];
            end
        end
    end

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic             w_rdy;
            logic             w_rdy_dn;
            logic             w_v;
            logic [WIDTH-1:0] w_d;
            logic             w_up_v;
            logic [WIDTH-1:0] w_up_d;

            if (k == 0) begin : g_head
                assign w_up_v = in_valid;
                assign w_up_d = w_sel_data;
            end else begin : g_body
                assign w_up_v = g_stage[k-1].w_v;
                assign w_up_d = g_stage[k-1].w_d;
            end

            if (k == DEPTH - 1) begin : g_tail
                assign w_rdy_dn = out_ready;
            end else begin : g_inner
                assign w_rdy_dn = g_stage[k+1].w_rdy;
            end

            sel_mux_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .rdy_in    (w_rdy_dn),
                .rdy_out   (w_rdy),
                .in_valid  (w_up_v),
                .in_data   (w_up_d),
                .out_valid (w_v),
                .out_data  (w_d)
            );
        end
    endgenerate

    assign in_ready  = g_stage[0].w_rdy;
    assign out_valid = g_stage[DEPTH-1].w_v;
    assign dout      = g_stage[DEPTH-1].w_d;

`ifdef SEL_MUX_PIPE_SELCHK_EN
    localparam logic [SEL_W:0] C_NUM_IN = (SEL_W+1)'(NUM_IN);

    logic w_sel_oob;
    logic r_sel_err;

    assign w_sel_oob = ({1'b0, sel} >= C_NUM_IN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else if (in_valid && in_ready && !flush && w_sel_oob) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`endif

endmodule : sel_mux_pipe

`default_nettype wire

// File: tb/tb_sel_mux_pipe.sv
// ============================================================================
// Module      : tb_sel_mux_pipe
// Description : Self-checking bench; drives DEPTH=1,2,3 instances in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sel_mux_pipe;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [14:0] din = {5'd9, 5'd7, 5'd3};
    logic [1:0]  sel = 2'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic [4:0]  dout_a [NDUT];
    logic        ov_a   [NDUT];
    logic        ir_a   [NDUT];
    logic        se_a   [NDUT];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Abstract model: per-instance slot arrays, index DEPTH-1 is the output.
    logic       m_v  [NDUT][4];
    logic [4:0] m_d  [NDUT][4];
    logic       m_se [NDUT];

    always #5 clk = ~clk;

    generate
        for (genvar n = 0; n < NDUT; n++) begin : g_dut
            sel_mux_pipe #(
                .WIDTH  (5),
                .NUM_IN (3),
                .SEL_W  (2),
                .DEPTH  (n + 1)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .din       (din),
                .sel       (sel),
                .in_valid  (in_valid),
                .in_ready  (ir_a[n]),
                .dout      (dout_a[n]),
                .out_valid (ov_a[n]),
`ifdef SEL_MUX_PIPE_SELCHK_EN
                .sel_err   (se_a[n]),
`endif
                .out_ready (out_ready)
            );
`ifndef SEL_MUX_PIPE_SELCHK_EN
            assign se_a[n] = 1'b0;
`endif
        end
    endgenerate

    function automatic logic [4:0] exp_opnd();
        int s;
        s = int'(sel);
        if (s >= 3) s = 0;
        return din[s*5 +: 5];
    endfunction

    // Ready iff any slot is empty or the tail is being taken.
    function automatic logic exp_ready(int n);
        logic r;
        r = out_ready;
        for (int k = 0; k <= n; k++) begin
            if (!m_v[n][k]) r = 1'b1;
        end
        return r;
    endfunction

    initial begin
        for (int n = 0; n < NDUT; n++) begin
            m_se[n] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                m_v[n][k] = 1'b0;
                m_d[n][k] = '0;
            end
        end
    end

    always @(posedge clk) begin
        int  last;
        int  hole;
        logic rdy;
        for (int n = 0; n < NDUT; n++) begin
            last = n;
            rdy  = exp_ready(n);
            if (reset) begin
                m_se[n] = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    m_v[n][k] = 1'b0;
                    m_d[n][k] = '0;
                end
            end else if (flush) begin
                for (int k = 0; k < 4; k++) m_v[n][k] = 1'b0;
            end else begin
                if (in_valid && rdy && sel >= 2'd3) m_se[n] = 1'b1;
                // Everything upstream of the highest free slot advances one place.
                hole = -1;
                if (m_v[n][last] && out_ready) begin
                    hole = last;
                end else begin
                    for (int k = last; k >= 0; k--) begin
                        if (!m_v[n][k] && hole < 0) hole = k;
                    end
                end
                for (int k = hole; k >= 1; k--) begin
                    if (m_v[n][k-1]) m_d[n][k] = m_d[n][k-1];
                    m_v[n][k] = m_v[n][k-1];
                end
                if (hole >= 0) begin
                    m_v[n][0] = in_valid;
                    if (in_valid) m_d[n][0] = exp_opnd();
                end
            end
        end
    end

    task automatic chk(input string name, input int n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, n, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int n = 0; n < NDUT; n++) begin
                chk("out_valid", n, 32'(ov_a[n]), 32'(m_v[n][n]));
                chk("in_ready", n, 32'(ir_a[n]), 32'(exp_ready(n)));
                chk("dout", n, 32'(dout_a[n]), 32'(m_d[n][n]));
`ifdef SEL_MUX_PIPE_SELCHK_EN
                chk("sel_err", n, 32'(se_a[n]), 32'(m_se[n]));
`endif
            end
        end
    end

    task automatic drive(input bit iv, input bit [1:0] s, input bit ordy, input bit fl);
        in_valid  = iv;
        sel       = s;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 2'd0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset and single item through DEPTH=1
        drive(1'b1, 2'd1, 1'b1, 1'b0);
        chk_en = 1'b1;
        drive(1'b1, 2'd1, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 0, 32'(ov_a[0]), 32'd0);
        chk("rst_dout", 2, 32'(dout_a[2]), 32'd0);
        chk("rst_in_ready", 1, 32'(ir_a[1]), 32'd1);
        drive(1'b1, 2'd1, 1'b1, 1'b0);
        chk("t1_dout", 0, 32'(dout_a[0]), 32'd7);
        chk("t1_valid", 0, 32'(ov_a[0]), 32'd1);
        idle(4);

        // Back-to-back stream through DEPTH=3
        drive(1'b1, 2'd0, 1'b1, 1'b0);
        drive(1'b1, 2'd1, 1'b1, 1'b0);
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        chk("t2_dout_c3", 2, 32'(dout_a[2]), 32'd3);
        chk("t2_dout_d1", 0, 32'(dout_a[0]), 32'd9);
        idle(1);
        chk("t2_dout_c4", 2, 32'(dout_a[2]), 32'd7);
        idle(1);
        chk("t2_dout_c5", 2, 32'(dout_a[2]), 32'd9);
        chk("t2_valid_c5", 2, 32'(ov_a[2]), 32'd1);
        idle(1);
        chk("t2_drained", 2, 32'(ov_a[2]), 32'd0);
        idle(2);

        // Backpressure: fill and hold, then release in order
        for (int i = 0; i < 5; i++) begin
            din = {5'(i + 20), 5'(i + 10), 5'(i + 1)};
            drive(1'b1, 2'(i % 3), 1'b0, 1'b0);
            if (i == 0) chk("t3_full_ready", 0, 32'(ir_a[0]), 32'd0);
            if (i == 1) begin
                chk("t3_full_ready", 1, 32'(ir_a[1]), 32'd0);
                chk("t3_part_ready", 2, 32'(ir_a[2]), 32'd1);
            end
            if (i == 2) chk("t3_full_ready", 2, 32'(ir_a[2]), 32'd0);
        end
        chk("t3_hold_dout", 1, 32'(dout_a[1]), 32'd1);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        chk("t3_release_dout", 1, 32'(dout_a[1]), 32'd11);
        din = {5'd9, 5'd7, 5'd3};
        idle(4);

        // Out-of-range select
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        chk("t4_oob_dout", 0, 32'(dout_a[0]), 32'd3);
`ifdef SEL_MUX_PIPE_SELCHK_EN
        chk("t4_sel_err", 0, 32'(se_a[0]), 32'd1);
`endif
        idle(4);
`ifdef SEL_MUX_PIPE_SELCHK_EN
        chk("t4_sel_err_sticky", 2, 32'(se_a[2]), 32'd1);
`endif

        // Flush of a full pipeline with a simultaneous offer
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        din = {5'd30, 5'd29, 5'd28};
        drive(1'b1, 2'd1, 1'b0, 1'b1);
        chk("t5_flush_valid", 2, 32'(ov_a[2]), 32'd0);
        din = {5'd9, 5'd7, 5'd3};
        idle(4);
        chk("t5_no_ghost", 2, 32'(ov_a[2]), 32'd0);

        // Reset while stalled, then fresh latency
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("t6_rst_valid", 2, 32'(ov_a[2]), 32'd0);
        chk("t6_rst_valid", 0, 32'(ov_a[0]), 32'd0);
        drive(1'b1, 2'd1, 1'b1, 1'b0);
        chk("t6_lat1", 0, 32'(dout_a[0]), 32'd7);
        chk("t6_lat_c1", 2, 32'(ov_a[2]), 32'd0);
        idle(1);
        chk("t6_lat_c2", 2, 32'(ov_a[2]), 32'd0);
        idle(1);
        chk("t6_lat_c3", 2, 32'(ov_a[2]), 32'd1);
        chk("t6_lat_dout", 2, 32'(dout_a[2]), 32'd7);
        idle(2);

        // Mixed traffic with stalls, one flush and out-of-range selects
        for (int i = 0; i < 40; i++) begin
            din = {5'(i * 3), 5'(i * 7), 5'(i + 5)};
            drive(((i % 4) != 3), 2'(i % 4), ((i % 5) < 3), (i == 25));
        end
        idle(5);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sel_mux_pipe

`default_nettype wire
